// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned restoring divider for DIV/DIVU in EX; result = {remainder, quotient}.
// Define DIV_RADIX4_EN to retire two quotient bits per cycle (16 iterations instead of 32).
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        cancel,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_req
);

`ifdef DIV_RADIX4_EN
  localparam int CW = 4;
`else
  localparam int CW = 5;
`endif
  // Both configurations terminate on an all-ones count (15 or 31).
  localparam logic [CW-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_ZERO = 2'd1,
    S_ON       = 2'd2,
    S_END      = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [64:0]     work, work_next;
  logic [31:0]     divisor;
  logic            quot_neg, rem_neg;
  logic [CW-1:0]   cnt;

  logic            op1_neg, op2_neg, accept;
  logic [31:0]     op1_mag, op2_mag;
  logic [31:0]     quot_fix, rem_fix;

  // One restoring step: the 34-bit window w[64:31] is the shifted partial
  // remainder with a guard bit, so the borrow is simply the MSB of the difference.
  function automatic logic [64:0] div_step(input logic [64:0] w, input logic [31:0] d);
    logic [33:0] diff;
    diff = w[64:31] - {2'b00, d};
    if (!diff[33]) div_step = {diff[32:0], w[30:0], 1'b1};
    else           div_step = {w[63:0], 1'b0};
  endfunction

  assign accept  = start & ~cancel;
  assign op1_neg = signed_div & opdata1[31];
  assign op2_neg = signed_div & opdata2[31];
  // Negating 0x8000_0000 yields 0x8000_0000, which is the correct unsigned magnitude.
  assign op1_mag = op1_neg ? (~opdata1 + 32'd1) : opdata1;
  assign op2_mag = op2_neg ? (~opdata2 + 32'd1) : opdata2;

  always_comb begin
    work_next = div_step(work, divisor);
`ifdef DIV_RADIX4_EN
    work_next = div_step(work_next, divisor);
`endif
  end

  assign quot_fix = quot_neg ? (~work_next[31:0]  + 32'd1) : work_next[31:0];
  assign rem_fix  = rem_neg  ? (~work_next[63:32] + 32'd1) : work_next[63:32];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (accept) state_next = (opdata2 == 32'd0) ? S_DIV_ZERO : S_ON;
      S_DIV_ZERO: state_next = S_END;
      S_ON:       if (cnt == CNT_LAST) state_next = S_END;
      S_END:      state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (cancel) state_next = S_IDLE;
  end

  always_comb begin
    stall_req = 1'b0;
    if (resetn && !cancel) begin
      unique case (state)
        S_IDLE:           stall_req = start;
        S_DIV_ZERO, S_ON: stall_req = 1'b1;
        default:          stall_req = 1'b0;
      endcase
    end
  end

  // Datapath: result/ready are written on the edge entering S_END so they are valid in that cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      work     <= '0;
      divisor  <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (!cancel) begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              divisor  <= op2_mag;
              quot_neg <= op1_neg ^ op2_neg;
              rem_neg  <= op1_neg;
              cnt      <= '0;
              // Divide-by-zero returns the raw dividend, so skip the magnitude there.
              work     <= {33'd0, (opdata2 == 32'd0) ? opdata1 : op1_mag};
            end
          end
          S_DIV_ZERO: begin
            result <= {work[31:0], 32'hFFFF_FFFF};
            ready  <= 1'b1;
          end
          S_ON: begin
            work <= work_next;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              result <= {rem_fix, quot_fix};
              ready  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for cancel, reset and back-to-back timing.
module tb_div_iter;

`ifdef DIV_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic        clk = 1'b0;
  logic        resetn, start, signed_div, cancel;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready, stall_req;

  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  logic [63:0] last_exp = '0;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .cancel     (cancel),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Start in cycle 0 (inputs driven at a negedge), then watch ready/stall_req each cycle.
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output bit seq_ok,
                        output int ready_at);
    @(negedge clk);
    signed_div = sd; opdata1 = a; opdata2 = b; start = 1'b1;
    #1;
    seq_ok   = (stall_req === 1'b1) && (ready === 1'b0);
    lat      = -1;
    res      = '0;
    ready_at = -1;
    for (int c = 1; c <= N + 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ready === 1'b1) begin
        lat      = c;
        res      = result;
        ready_at = cyc_cnt;
        if (stall_req !== 1'b0) seq_ok = 1'b0;
        break;
      end
      if (stall_req !== 1'b1) seq_ok = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] res, exp;
    int          lat, rdy1, rdy2, exp_lat;
    bit          seq_ok, ready_seen;
    logic        sd;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                    N + 1};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},     N + 1};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD},     N + 1};
    vecs[3] = '{1'b0, 32'h0000_1234,  32'd0,          {32'h0000_1234, 32'hFFFF_FFFF},     2};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},             N + 1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF},     2};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},             N + 1};

    // Reset: outputs zero and stall_req forced low even with start asserted.
    resetn = 1'b0; start = 1'b1; cancel = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd1; opdata2 = 32'd1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_result", result, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_stall", {63'd0, stall_req}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].sd, vecs[i].a, vecs[i].b, res, lat, seq_ok, rdy1);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_stall_seq", i), {63'd0, seq_ok}, 64'd1);
      last_exp = vecs[i].exp;
    end

    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'd0 - 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp     = ref_div(sd, a, b);
      exp_lat = (b == 32'd0) ? 2 : N + 1;
      run_op(sd, a, b, res, lat, seq_ok, rdy1);
      check($sformatf("rand%0d_result", i), res, exp);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("rand%0d_stall_seq", i), {63'd0, seq_ok}, 64'd1);
      last_exp = exp;
    end

    // Cancel in cycle 10 of DIVU 100/7, then DIVU 9/3 started in cycle 12.
    ready_seen = 1'b0;
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ready === 1'b1) ready_seen = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel_stall_c10", {63'd0, stall_req}, 64'd0);
    if (ready === 1'b1) ready_seen = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_stall_c11", {63'd0, stall_req}, 64'd0);
    check("cancel_result_kept", result, last_exp);
    if (ready === 1'b1) ready_seen = 1'b1;
    check("cancel_no_ready", {63'd0, ready_seen}, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, res, lat, seq_ok, rdy1);
    check("after_cancel_result", res, {32'd0, 32'd3});
    check("after_cancel_latency", 64'(lat), 64'(N + 1));
    last_exp = {32'd0, 32'd3};

    // start and cancel together in IDLE: nothing accepted.
    ready_seen = 1'b0;
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd5; opdata2 = 32'd1; start = 1'b1; cancel = 1'b1;
    #1;
    check("start_cancel_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    check("start_cancel_not_accepted", {63'd0, stall_req}, 64'd0);
    repeat (N + 3) begin
      @(negedge clk);
      #1;
      if (ready === 1'b1) ready_seen = 1'b1;
    end
    check("start_cancel_no_ready", {63'd0, ready_seen}, 64'd0);
    check("start_cancel_result_kept", result, last_exp);

    // cancel during the END cycle: ready already registered stays high.
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'h0000_1234; opdata2 = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel_end_ready", {63'd0, ready}, 64'd1);
    check("cancel_end_result", result, {32'h0000_1234, 32'hFFFF_FFFF});
    @(negedge clk);
    cancel = 1'b0;
    last_exp = {32'h0000_1234, 32'hFFFF_FFFF};

    // Asynchronous reset in cycle 20 of an operation.
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_result", result, 64'd0);
    check("midreset_ready", {63'd0, ready}, 64'd0);
    check("midreset_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    ready_seen = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      #1;
      if (ready === 1'b1) ready_seen = 1'b1;
    end
    check("midreset_no_ready", {63'd0, ready_seen}, 64'd0);

    // Back-to-back: second start the cycle after the first ready.
    run_op(1'b0, 32'd1000, 32'd33, res, lat, seq_ok, rdy1);
    check("b2b_first_result", res, {32'd10, 32'd30});
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, res, lat, seq_ok, rdy2);
    check("b2b_second_result", res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    check("b2b_second_seq", {63'd0, seq_ok}, 64'd1);
    check("b2b_spacing", 64'(rdy2 - rdy1), 64'(N + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit signed/unsigned divider in the EX stage, serving DIV/DIVU. Accepts one operation per request, stalls the pipeline while it computes, and returns {remainder, quotient} for the HI/LO registers. That result is later forwarded toward ID through `ex_to_id_bus` (MFHI/MFLO) and reaches the register file via WB.

## Interface
Parameters: none. Radix is selected by the macro under Configuration.

- `clk` in 1: pipeline clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: divide request from EX. Level-sensitive; sampled only in IDLE.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU. Latched with `start`.
- `opdata1` in 32: dividend. Latched with `start`.
- `opdata2` in 32: divisor. Latched with `start`.
- `cancel` in 1: exception/flush. Aborts any operation.
- `result` out 64: {remainder[63:32] → HI, quotient[31:0] → LO}. Registered.
- `ready` out 1: result valid. Registered, one-cycle pulse.
- `stall_req` out 1: hold IF/ID/EX. Combinational.

## Operation
- States: IDLE, DIV_ZERO, ON, END.
- **IDLE**
  - `start` & !`cancel` & `opdata2`==0 → DIV_ZERO.
  - `start` & !`cancel` & `opdata2`!=0 → ON.
  - On acceptance: latch operands and `signed_div`; clear iteration counter.
- **DIV_ZERO**: → END. Result = {`opdata1`, 32'hFFFF_FFFF}, independent of `signed_div`.
- **ON**
  - Operates on absolute values (signed mode) or raw values (unsigned mode).
  - Restoring shift-subtract, 65-bit working register.
  - Each iteration: shift left; trial-subtract divisor from the upper half; on no-borrow, replace the upper half and set quotient bit = 1.
  - After N iterations → END.
- **END**
  - `result` is registered with signs corrected: quotient negated when the operand signs differ; remainder takes the sign of the dividend.
  - `ready` = 1 for exactly this cycle.
  - → IDLE unconditionally. `start` is ignored in END.
- |0x8000_0000| is taken as unsigned 0x8000_0000. Therefore 0x8000_0000 / 0xFFFF_FFFF (signed) gives quotient 0x8000_0000, remainder 0 (wraps, no trap).
- **`stall_req`** = 1 when any of:
  - IDLE & `start` & !`cancel`;
  - state is DIV_ZERO;
  - state is ON.
  
  It is 0 in END and whenever `cancel` = 1.
- **`cancel`**: in any state, next edge → IDLE, `ready` stays 0, `result` unchanged. Same cycle as `start` in IDLE: cancel wins, nothing accepted.
- **`result`** holds its value until the next END. It is not cleared on cancel or on a new `start`.

## Timing
- Reset (async, `resetn` low): state = IDLE, `result` = 0, `ready` = 0, `stall_req` = 0 (forced while reset is asserted).
- `start` accepted at edge of cycle 0 (i.e. high during cycle 0).
  - Normal: `ready` = 1 in cycle N+1. Radix-2: N=32 → cycle 33. Radix-4: N=16 → cycle 17.
  - Divisor zero: `ready` = 1 in cycle 2.
- `stall_req` is 1 from cycle 0 through cycle N (inclusive) and 0 in the `ready` cycle, so EX advances on the edge ending that cycle.
- Back-to-back: a `start` presented in the cycle after `ready` (IDLE) is accepted. Minimum spacing between `ready` pulses is N+2 cycles.
- Reset mid-operation: immediate return to IDLE. Outputs go to their reset values, and no `ready` is issued for the aborted operation.
- `cancel` in the END cycle: `ready` is still 1 in that cycle (already registered). The pipeline flush discards it.

## Configuration
- Macro `DIV_RADIX4_EN`.
- **Defined**: two quotient bits per ON cycle.
  - Two chained trial subtractions (divisor, then divisor on the shifted partial remainder).
  - N = 16; the counter is 4 bits wide and terminates at 15.
- **Undefined**: one bit per cycle, N = 32, 5-bit counter terminating at 31.
- Unchanged in both configurations: results, DIV_ZERO path, cancel and reset behaviour. Only the latency differs.

## Test plan
- **Unsigned**: DIVU 100/7, `start` in cycle 0 → `ready` in cycle 33 (17 with `DIV_RADIX4_EN`); `result` = {32'd2, 32'd14}. `stall_req` is 1 in cycles 0..32 and 0 in cycle 33.
- **Signed**: DIV 0xFFFF_FFF9 (−7) / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Then DIV 7 / 0xFFFF_FFFE → quotient 0xFFFF_FFFD, remainder 0x0000_0001.
- **Divide by zero and overflow**
  - DIVU 0x1234 / 0 → `ready` in cycle 2; `result` = {0x0000_1234, 0xFFFF_FFFF}.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → {0, 0x8000_0000}.
- **Cancel**: `start` DIVU 100/7 in cycle 0, `cancel` in cycle 10.
  - Expect: `ready` never pulses; `stall_req` = 0 from cycle 10; `result` unchanged.
  - Then `start` DIVU 9/3 in cycle 12 → `ready` in cycle 45 with {0, 3}.
  - Also drive `start` and `cancel` together in IDLE → nothing accepted.
- **Reset and back-to-back**
  - Drop `resetn` in cycle 20 of an operation → state IDLE; `result`/`ready`/`stall_req` = 0 asynchronously.
  - After release, two back-to-back ops (new `start` the cycle after `ready`) → both results correct; `ready` pulses 34 cycles apart (18 with radix-4).
